// File: rtl/sbq_teller_dispatch_if.sv
// rtl/sbq_teller_dispatch_if.sv - teller dispatch bus; served_cnt present when SBQ_DISP_STATS_EN is defined
interface sbq_teller_dispatch_if #(
   parameter int N = 3
);
   logic [2:0]   teller_next;
   logic [1:0]   Tcount;
   logic         empty;
   logic         call_valid;
   logic [1:0]   call_teller;
   logic [N-1:0] call_ticket;
   logic         dequeue;
   logic [2:0]   busy;
   logic [2:0]   pend;
`ifdef SBQ_DISP_STATS_EN
   logic [7:0]   served_cnt;

   modport master (
      input  teller_next, Tcount, empty,
      output call_valid, call_teller, call_ticket, dequeue, busy, pend, served_cnt
   );
   modport slave (
      output teller_next, Tcount, empty,
      input  call_valid, call_teller, call_ticket, dequeue, busy, pend, served_cnt
   );
`else
   modport master (
      input  teller_next, Tcount, empty,
      output call_valid, call_teller, call_ticket, dequeue, busy, pend
   );
   modport slave (
      output teller_next, Tcount, empty,
      input  call_valid, call_teller, call_ticket, dequeue, busy, pend
   );
`endif
endinterface

// File: rtl/sbq_teller_dispatch.sv
// rtl/sbq_teller_dispatch.sv - round-robin teller call dispatcher; optional served counter via SBQ_DISP_STATS_EN
module sbq_teller_dispatch #(
   parameter int N   = 3,
   parameter int GAP = 2
) (
   input logic                   clk,
   input logic                   rst,
   sbq_teller_dispatch_if.master bus
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALL = 2'd1, S_GAP = 2'd2} state_t;

   localparam logic [N-1:0] TICKET_ONE = {{(N-1){1'b0}}, 1'b1};
   localparam logic [3:0]   GAP_LOAD   = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   state_t       state, state_nxt;
   logic [2:0]   enabled, eligible, press;
   logic [2:0]   pend_q, busy_q, pend_nxt, busy_nxt;
   logic [1:0]   ptr, grant, teller_q;
   logic [N-1:0] ticket_cnt, ticket_q;
   logic [3:0]   gap_cnt;
   logic         found;

   // (base + offs) mod 3 for base, offs in 0..2
   function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] offs);
      logic [2:0] sum;
      sum = {1'b0, base} + {1'b0, offs};
      return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
   endfunction

   assign enabled  = {bus.Tcount == 2'd3, bus.Tcount >= 2'd2, bus.Tcount != 2'd0};
   assign eligible = pend_q & enabled;

   // round-robin search from ptr; descending loop so the nearest candidate wins
   always_comb begin
      grant = ptr;
      found = 1'b0;
      for (int k = 2; k >= 0; k--) begin
         if (eligible[rr_idx(ptr, 2'(k))]) begin
            grant = rr_idx(ptr, 2'(k));
            found = 1'b1;
         end
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (found && !bus.empty) state_nxt = S_CALL;
         S_CALL:  state_nxt = (GAP == 0) ? S_IDLE : S_GAP;
         S_GAP:   if (gap_cnt == 4'd0) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // call strobes decoded from state
   always_comb begin
      bus.call_valid = (state == S_CALL);
      bus.dequeue    = (state == S_CALL);
   end

   // pend/busy update: presses latch, disabled tellers clear, the CALL exit serves the grant
   always_comb begin
      press    = bus.teller_next & enabled & ~pend_q;
      pend_nxt = (pend_q | press) & enabled;
      busy_nxt = busy_q & ~press & enabled;
      if (state == S_CALL) begin
         pend_nxt[teller_q] = 1'b0;
         busy_nxt[teller_q] = enabled[teller_q];
      end
   end

   // grant latch, ticket counter, pointer and gap timer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_q     <= '0;
         busy_q     <= '0;
         ptr        <= '0;
         teller_q   <= '0;
         ticket_q   <= '0;
         ticket_cnt <= '0;
         gap_cnt    <= '0;
      end else begin
         pend_q <= pend_nxt;
         busy_q <= busy_nxt;
         if (state == S_IDLE && found && !bus.empty) begin
            teller_q <= grant;
            ticket_q <= ticket_cnt;
         end
         if (state == S_CALL) begin
            ticket_cnt <= ticket_cnt + TICKET_ONE;
            ptr        <= rr_idx(teller_q, 2'd1);
            gap_cnt    <= GAP_LOAD;
         end else if (state == S_GAP && gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
         end
      end
   end

   assign bus.call_teller = teller_q;
   assign bus.call_ticket = ticket_q;
   assign bus.pend        = pend_q;
   assign bus.busy        = busy_q;

`ifdef SBQ_DISP_STATS_EN
   logic [7:0] served_q;

   // saturating count of completed calls
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                    served_q <= '0;
      else if (state == S_CALL && served_q != 8'hFF) served_q <= served_q + 8'd1;
   end

   assign bus.served_cnt = served_q;
`endif
endmodule

// File: tb/tb_sbq_teller_dispatch.sv
// tb/tb_sbq_teller_dispatch.sv - scoreboard bench for sbq_teller_dispatch
module tb_sbq_teller_dispatch;
   localparam int N   = 3;
   localparam int GAP = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sbq_teller_dispatch_if #(.N(N)) bus ();
   sbq_teller_dispatch #(.N(N), .GAP(GAP)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {int teller; int ticket;} call_t;
   call_t exp_q[$];
   int    obs_tickets[$];
   int    obs_tellers[$];
   int    obs_cyc[$];

   bit [2:0] m_pend, m_busy;
   int       m_ptr, m_ticket, m_hold, m_calling, m_served;

   task automatic chk(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_pend = '0; m_busy = '0; m_ptr = 0; m_ticket = 0;
      m_hold = 0; m_calling = -1; m_served = 0;
      exp_q.delete();
   endfunction

   // reference: tellers hold a pending flag; an idle dispatcher serves the first
   // eligible pending teller at or after ptr, then rests GAP cycles
   function automatic void model_step();
      bit [2:0] en, old_pend;
      int g;
      if (!rst) begin
         model_reset();
         return;
      end
      old_pend = m_pend;
      for (int i = 0; i < 3; i++) en[i] = (i < int'(bus.Tcount));
      for (int i = 0; i < 3; i++) begin
         if (!en[i]) begin
            m_pend[i] = 0; m_busy[i] = 0;
         end else if (bus.teller_next[i] && !m_pend[i]) begin
            m_pend[i] = 1; m_busy[i] = 0;
         end
      end
      if (m_calling >= 0) begin
         g = m_calling;
         m_pend[g] = 0;
         m_busy[g] = en[g];
         m_ticket  = (m_ticket + 1) % (1 << N);
         m_ptr     = (g + 1) % 3;
         if (m_served < 255) m_served++;
         m_hold    = GAP;
         m_calling = -1;
      end else if (m_hold > 0) begin
         m_hold--;
      end else if (!bus.empty) begin
         g = -1;
         for (int k = 0; k < 3; k++)
            if (g < 0 && old_pend[(m_ptr + k) % 3] && en[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
         if (g >= 0) begin
            exp_q.push_back('{teller: g, ticket: m_ticket});
            m_calling = g;
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #2;
   endtask

   task automatic idle(int n);
      repeat (n) tick();
   endtask

   task automatic press(bit [2:0] v);
      bus.teller_next = v;
      tick();
      bus.teller_next = 3'b000;
   endtask

   task automatic check_zero(string tag);
      chk({tag, "_call_valid"},  bus.call_valid, 0);
      chk({tag, "_dequeue"},     bus.dequeue, 0);
      chk({tag, "_call_teller"}, bus.call_teller, 0);
      chk({tag, "_call_ticket"}, bus.call_ticket, 0);
      chk({tag, "_busy"},        bus.busy, 0);
      chk({tag, "_pend"},        bus.pend, 0);
   endtask

   task automatic do_reset();
      bus.teller_next = 3'b000;
      bus.Tcount      = 2'd3;
      bus.empty       = 1'b0;
      rst = 1'b0;
      model_reset();
      #1;
      check_zero("reset");
      idle(2);
      rst = 1'b1;
      obs_tickets.delete(); obs_tellers.delete(); obs_cyc.delete();
   endtask

   // monitor: pops expected calls and tracks per-cycle teller flags
   initial begin
      call_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst === 1'b1) begin
            if (bus.call_valid) begin
               obs_tickets.push_back(int'(bus.call_ticket));
               obs_tellers.push_back(int'(bus.call_teller));
               obs_cyc.push_back(cyc);
               chk("call_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("call_teller", bus.call_teller, e.teller);
                  chk("call_ticket", bus.call_ticket, e.ticket);
               end
               chk("dequeue_hi", bus.dequeue, 1);
            end else begin
               chk("dequeue_lo", bus.dequeue, 0);
            end
            chk("pend", bus.pend, m_pend);
            chk("busy", bus.busy, m_busy);
`ifdef SBQ_DISP_STATS_EN
            chk("served_cnt", bus.served_cnt, m_served);
`endif
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // single press, then busy set and pend cleared
      press(3'b001);
      tick();
      chk("first_valid",  bus.call_valid, 1);
      chk("first_deq",    bus.dequeue, 1);
      chk("first_teller", bus.call_teller, 0);
      chk("first_ticket", bus.call_ticket, 0);
      tick();
      chk("first_busy", bus.busy, 3'b001);
      chk("first_pend", bus.pend, 3'b000);
      idle(6);

      // simultaneous presses served in round-robin order, GAP+1 idle cycles apart
      do_reset();
      press(3'b111);
      idle(20);
      chk("rr_count", obs_tellers.size(), 3);
      if (obs_tellers.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            chk("rr_teller", obs_tellers[i], i);
            chk("rr_ticket", obs_tickets[i], i);
         end
         chk("rr_spacing01", obs_cyc[1] - obs_cyc[0], GAP + 2);
         chk("rr_spacing12", obs_cyc[2] - obs_cyc[1], GAP + 2);
      end

      // empty queue holds the request until it fills
      do_reset();
      bus.empty = 1'b1;
      press(3'b010);
      idle(8);
      chk("empty_pend",  bus.pend, 3'b010);
      chk("empty_calls", obs_tellers.size(), 0);
      bus.empty = 1'b0;
      tick();
      chk("empty_release_valid",  bus.call_valid, 1);
      chk("empty_release_teller", bus.call_teller, 1);
      idle(6);

      // disabled tellers are ignored; Tcount=0 never calls
      do_reset();
      bus.Tcount = 2'd1;
      press(3'b100);
      idle(3);
      chk("disabled_pend", bus.pend, 3'b000);
      bus.Tcount = 2'd0;
      repeat (30) begin
         bus.teller_next = 3'($urandom_range(0, 7));
         tick();
      end
      bus.teller_next = 3'b000;
      idle(5);
      chk("disabled_calls", obs_tellers.size(), 0);

      // ticket wrap over 9 calls
      do_reset();
      for (int i = 0; i < 9; i++) begin
         press(3'b001);
         idle(5);
      end
      chk("wrap_count", obs_tickets.size(), 9);
      if (obs_tickets.size() == 9)
         for (int i = 0; i < 9; i++) chk("wrap_ticket", obs_tickets[i], i % 8);

      // reset during CALL: no dequeue afterwards
      do_reset();
      press(3'b001);
      tick();
      rst = 1'b0;
      model_reset();
      #1;
      check_zero("rst_call");
      tick();
      rst = 1'b1;
      idle(3);

      // reset during GAP
      do_reset();
      press(3'b001);
      idle(2);
      rst = 1'b0;
      model_reset();
      #1;
      check_zero("rst_gap");
      tick();
      rst = 1'b1;
      idle(3);

      // randomized traffic against the model
      do_reset();
      repeat (1500) begin
         bus.teller_next = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
         if ($urandom_range(0, 40) == 0) bus.Tcount = 2'($urandom_range(0, 3));
         bus.empty = ($urandom_range(0, 4) == 0);
         tick();
      end
      bus.teller_next = 3'b000;
      bus.Tcount      = 2'd3;
      bus.empty       = 1'b0;
      idle(20);

`ifdef SBQ_DISP_STATS_EN
      do_reset();
      bus.teller_next = 3'b111;
      repeat (1300) tick();
      bus.teller_next = 3'b000;
      idle(20);
      chk("served_calls", obs_tickets.size() >= 300, 1);
      chk("served_sat", bus.served_cnt, 255);
`endif

      chk("leftover_expected", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sbq_teller_dispatch.md
SBQ_TELLER_DISPATCH -- requirements
Module: sbq_teller_dispatch

Interface
REQ-001 SHALL have parameter N, default 3: ticket-number width, matching the queue counter's Pcount width.
REQ-002 SHALL have parameter GAP, default 2: display-hold cycles after each call, range 0..15.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port teller_next, input, 3: one-cycle pulse per teller; bit i means teller i is finished and requests the next customer.
REQ-006 SHALL have port Tcount, input, 2: number of active tellers, 0..3; teller i is enabled iff i < Tcount.
REQ-007 SHALL have port empty, input, 1: queue-empty flag from the queue counter.
REQ-008 SHALL have port call_valid, output, 1: high exactly one cycle per customer call.
REQ-009 SHALL have port call_teller, output, 2: granted teller index; valid while call_valid is high.
REQ-010 SHALL have port call_ticket, output, N: ticket number of the called customer; valid while call_valid is high.
REQ-011 SHALL have port dequeue, output, 1: one-cycle pulse equal to call_valid, driving the queue counter's exit input.
REQ-012 SHALL have port busy, output, 3: teller i is serving a customer.
REQ-013 SHALL have port pend, output, 3: teller i has a latched, unserved request.

Function
REQ-014 SHALL implement FSM states IDLE, CALL and GAP, with all outputs registered or decoded from state.
REQ-015 SHALL set pend[i] at the edge sampling teller_next[i]=1 if teller i is enabled; the same edge SHALL clear busy[i]; a press while pend[i]=1 has no further effect.
REQ-016 IDLE: at an edge where (pend & enabled)!=0 and empty=0, SHALL pick grant g by round-robin starting at pointer ptr, latch call_teller=g and call_ticket=ticket_cnt, and go to CALL.
REQ-017 IDLE with empty=1 or no eligible pend SHALL hold all state, with pend retained indefinitely.
REQ-018 CALL SHALL last one cycle with call_valid=dequeue=1; at its exit edge it SHALL clear pend[g], set busy[g], increment ticket_cnt modulo 2^N (2^N-1 wraps to 0), and set ptr=(g+1) mod 3.
REQ-019 After CALL the FSM SHALL go to GAP for exactly GAP cycles, then IDLE; with GAP=0 it SHALL go directly to IDLE.
REQ-020 Latency SHALL be: press at edge k gives pend at k; with a nonempty queue and FSM in IDLE, CALL is entered at edge k+1 and call_valid is high in cycle k+1..k+2.
REQ-021 A teller_next[g] press sampled at the CALL exit edge SHALL be dropped; pend[g] is 0 and busy[g] is 1 afterwards.
REQ-022 When Tcount drops so that teller i is disabled, pend[i] and busy[i] SHALL clear at the next edge; a CALL already entered for i SHALL still complete.
REQ-023 With Tcount=0 no call SHALL ever be issued.
REQ-024 With multiple simultaneous presses, all SHALL latch and be served one per call in round-robin order.

Reset
REQ-025 rst=0 SHALL immediately force state=IDLE, call_valid=0, dequeue=0, call_teller=0, call_ticket=0, busy=0, pend=0, ticket_cnt=0, ptr=0 and the gap counter to 0.
REQ-026 Reset asserted during CALL or GAP SHALL abort the operation, with no dequeue pulse and no ticket increment.

Configuration
REQ-027 With macro SBQ_DISP_STATS_EN defined, SHALL add output served_cnt, 8 bits, reset 0, incremented at each CALL exit edge and saturating at 255.
REQ-028 Without SBQ_DISP_STATS_EN, the served_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 Tcount=3, empty=0, pulse teller_next=3'b001 -> one cycle later call_valid=1, dequeue=1, call_teller=0, call_ticket=0; afterwards busy=3'b001 and pend=0.
REQ-030 Pulse teller_next=3'b111 in one cycle with ptr=0 -> calls to teller 0, 1 and 2 in that order, each separated by GAP+1 idle cycles, with call_ticket 0, 1, 2.
REQ-031 empty=1, press teller 1 -> no call and pend=3'b010 held; deassert empty -> call to teller 1 on the next edge.
REQ-032 Tcount=1, press teller 2 -> pend stays 0 and no call; Tcount=0 with any presses -> no call_valid ever.
REQ-033 Issue 9 calls with N=3 -> call_ticket sequence 0..7, 0 (wrap).
REQ-034 Assert rst=0 mid-GAP -> all outputs 0 immediately; with SBQ_DISP_STATS_EN defined, 300 calls -> served_cnt=255.
